// File: rtl/mux_sel_pipe.sv
// rtl/mux_sel_pipe.sv - NUM_IN:1 word selector with registered valid/ready output and skid buffer
//
// Purpose:
//   Selects in_data word in_sel (or zero when in_sel >= NUM_IN) and hands it
//   downstream through an output register plus one skid register.
//   in_ready depends only on registered state and reset, never on out_ready.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_data    NUM_IN packed words; word k = in_data[k*N +: N]
//   in_sel     word index, sampled with in_valid
//   in_valid   upstream word valid
//   in_ready   block can accept this cycle
//   out_data   selected word (registered)
//   out_valid  out_data valid
//   out_ready  downstream accepts out_data
//   sel_err    out-of-range select flag for the word on out_data
//
// Configuration macro: MUXP_SEL_ERR_EN
//   defined   -> sel_err travels with each word through OREG/SKID
//   undefined -> sel_err tied 0, flag storage not built

module mux_sel_pipe #(
  parameter int N      = 32,
  parameter int NUM_IN = 16,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IN*N-1:0] in_data,
  input  logic [SEL_W-1:0]    in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [N-1:0]        out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                sel_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // OREG empty, SKID empty
    ONE   = 2'd1,  // OREG full,  SKID empty
    FULL  = 2'd2   // OREG full,  SKID full
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   oreg_q, oreg_d;
  logic [N-1:0]   skid_q, skid_d;
  logic [N-1:0]   sel_word;
  logic           accept, drain;
  logic           oreg_ld_in, oreg_ld_skid, skid_ld;

  // One-hot masked words OR-ed together; an out-of-range select matches no
  // index and therefore yields zero.
  logic [NUM_IN-1:0][N-1:0] masked;

  for (genvar k = 0; k < NUM_IN; k++) begin : g_mux
    assign masked[k] = (in_sel == SEL_W'(k)) ? in_data[k*N +: N] : '0;
  end

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      sel_word = sel_word | masked[i];
    end
  end

  assign in_ready  = (state_q != FULL) & ~reset;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = oreg_q;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    oreg_ld_in   = 1'b0;
    oreg_ld_skid = 1'b0;
    skid_ld      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d    = ONE;
          oreg_ld_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && drain) begin
          oreg_ld_in = 1'b1;
        end else if (accept) begin
          state_d = FULL;
          skid_ld = 1'b1;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          state_d      = ONE;
          oreg_ld_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    oreg_d = oreg_q;
    skid_d = skid_q;
    if (oreg_ld_in) begin
      oreg_d = sel_word;
    end else if (oreg_ld_skid) begin
      oreg_d = skid_q;
    end
    if (skid_ld) begin
      skid_d = sel_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      oreg_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      oreg_q  <= oreg_d;
      skid_q  <= skid_d;
    end
  end

`ifdef MUXP_SEL_ERR_EN
  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

  logic in_err;
  logic oerr_q, oerr_d;
  logic serr_q, serr_d;

  assign in_err = ({1'b0, in_sel} >= NUM_IN_W);

  // Flags follow exactly the same load paths as the data words.
  always_comb begin
    oerr_d = oerr_q;
    serr_d = serr_q;
    if (oreg_ld_in) begin
      oerr_d = in_err;
    end else if (oreg_ld_skid) begin
      oerr_d = serr_q;
    end
    if (skid_ld) begin
      serr_d = in_err;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      oerr_q <= 1'b0;
      serr_q <= 1'b0;
    end else begin
      oerr_q <= oerr_d;
      serr_q <= serr_d;
    end
  end

  // OREG keeps its last flag after draining, so qualify with out_valid.
  assign sel_err = oerr_q & out_valid;
`else
  assign sel_err = 1'b0;
`endif

endmodule
